// File: rtl/gcd_pkg.sv
// gcd_pkg: shared constants for the GCD arbiter slice.
// Holds the FSM state encodings and the default width and requester count.
package gcd_pkg;

    localparam int unsigned GCD_W       = 8;
    localparam int unsigned GCD_NUM_REQ = 4;

    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_ISSUE = 2'd1;
    localparam logic [ST_W-1:0] ST_WAIT  = 2'd2;
    localparam logic [ST_W-1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/gcd_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
// Searches req starting at ptr and wrapping modulo N; grant is one-hot or zero.
module rr_arbiter #(
    parameter  int unsigned N   = 4,
    localparam int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx
);

    int unsigned    cand;
    logic [IDW-1:0] cand_idx;
    logic           found;

    // First requester at or after ptr in circular order wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDW'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: shares one external GCD engine between NUM_REQ requesters.
// Optional build macro GCD_ARB_ZERO_BYPASS_EN answers zero-operand requests
// directly (result a|b) without running the engine.
module gcd_arbiter
    import gcd_pkg::*;
#(
    parameter  int unsigned NUM_REQ = GCD_NUM_REQ,
    parameter  int unsigned W       = GCD_W,
    localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [W-1:0]         resp_gcd,
    output logic                 eng_start,
    output logic [W-1:0]         eng_a,
    output logic [W-1:0]         eng_b,
    input  logic [W-1:0]         eng_gcd,
    input  logic                 eng_done
);

    logic [ST_W-1:0]    state;
    logic [ST_W-1:0]    state_next;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     rr_ptr_next;
    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_idx;
    logic [W-1:0]       sel_a;
    logic [W-1:0]       sel_b;
    logic               take;
    logic               bypass;
    logic               done_take;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Operands of the currently selected requester and the pointer after it
    always_comb begin
        sel_a       = req_a[32'(grant_idx) * W +: W];
        sel_b       = req_b[32'(grant_idx) * W +: W];
        rr_ptr_next = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, combinational accept and event strobes
    always_comb begin
        state_next = state;
        req_ready  = '0;
        take       = 1'b0;
        bypass     = 1'b0;
        done_take  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|req_valid) begin
                    req_ready  = grant;
                    take       = 1'b1;
                    state_next = ST_ISSUE;
`ifdef GCD_ARB_ZERO_BYPASS_EN
                    if ((sel_a == '0) || (sel_b == '0)) begin
                        bypass     = 1'b1;
                        state_next = ST_RESP;
                    end
`endif
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (eng_done) begin
                    done_take  = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered datapath: operand/ID capture, start pulse, result and valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            eng_start  <= 1'b0;
            eng_a      <= '0;
            eng_b      <= '0;
            resp_id    <= '0;
            resp_gcd   <= '0;
            resp_valid <= 1'b0;
        end else begin
            eng_start  <= take && !bypass;
            resp_valid <= (state_next == ST_RESP);
            if (take) begin
                eng_a   <= sel_a;
                eng_b   <= sel_b;
                resp_id <= grant_idx;
                rr_ptr  <= rr_ptr_next;
            end
            if (done_take) begin
                resp_gcd <= eng_gcd;
            end else if (bypass) begin
                resp_gcd <= sel_a | sel_b;
            end
        end
    end

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: directed bench with a response scoreboard and a behavioural
// GCD engine model (fixed latency, done held until the next start).
module tb_gcd_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned W   = 8;
    localparam int unsigned IDW = 2;
    localparam int unsigned LAT = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic             resp_valid;
    logic             resp_ready;
    logic [IDW-1:0]   resp_id;
    logic [W-1:0]     resp_gcd;
    logic             eng_start;
    logic [W-1:0]     eng_a;
    logic [W-1:0]     eng_b;
    logic [W-1:0]     eng_gcd  = '0;
    logic             eng_done = 1'b0;

    always #5 clk = ~clk;

    gcd_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_gcd   (resp_gcd),
        .eng_start  (eng_start),
        .eng_a      (eng_a),
        .eng_b      (eng_b),
        .eng_gcd    (eng_gcd),
        .eng_done   (eng_done)
    );

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          n_start = 0;
    int          n_grant = 0;
    int          accept_cyc = 0;
    int          start_cyc  = 0;
    int          done_rise  = 0;
    int          resp_rise  = 0;
    logic        prev_done = 1'b0;
    logic        prev_rv   = 1'b0;
    logic [N-1:0] hold = '0;
    int          exp_id[$];
    int          exp_gcd[$];
    int          eng_cnt = 0;
    logic [W-1:0] eng_res = '0;

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] t;
        x = a;
        y = b;
        for (int k = 0; k < 64 && y != 0; k++) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Engine model: start clears done, result appears LAT cycles later
    always @(posedge clk) begin
        if (eng_start === 1'b1) begin
            eng_done <= 1'b0;
            eng_cnt  <= LAT;
            eng_res  <= ref_gcd(eng_a, eng_b);
        end else if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) begin
                eng_done <= 1'b1;
                eng_gcd  <= eng_res;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge (scoreboard, grants, events), drive after posedge
    task automatic cycle();
        logic [N-1:0] drop;
        drop = '0;
        @(negedge clk);
        cyc++;
        if (eng_start === 1'b1) begin
            n_start++;
            start_cyc = cyc;
        end
        if (eng_done && !prev_done) done_rise = cyc;
        prev_done = eng_done;
        if ((resp_valid === 1'b1) && !prev_rv) resp_rise = cyc;
        prev_rv = (resp_valid === 1'b1);
        if ((resp_valid === 1'b1) && resp_ready) begin
            if (exp_id.size() == 0) begin
                check("unexpected_resp", 32'(exp_id.size()), 32'd1);
            end else begin
                check("resp_id", 32'(resp_id), 32'(exp_id.pop_front()));
                check("resp_gcd", 32'(resp_gcd), 32'(exp_gcd.pop_front()));
            end
        end
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && (req_ready[i] === 1'b1)) begin
                n_grant++;
                accept_cyc = cyc;
                if (!hold[i]) drop[i] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        req_valid = req_valid & ~drop;
    endtask

    task automatic request(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int g, input bit expect_resp);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_valid[i]    = 1'b1;
        if (expect_resp) begin
            exp_id.push_back(i);
            exp_gcd.push_back(g);
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_id.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        check(tag, 32'(exp_id.size()), 32'd0);
    endtask

    initial begin
        int s0;
        int g0;
        int n;
        bit seen;

        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        cycle();
        cycle();
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_eng_start",  32'(eng_start),  32'd0);
        check("rst_resp_id",    32'(resp_id),    32'd0);
        check("rst_resp_gcd",   32'(resp_gcd),   32'd0);
        check("rst_eng_a",      32'(eng_a),      32'd0);
        check("rst_eng_b",      32'(eng_b),      32'd0);
        check("rst_req_ready",  32'(req_ready),  32'd0);
        rst_n = 1'b1;
        cycle();

        // Simultaneous requests from all four: served in order 0,1,2,3
        request(0, 8'd81,  8'd27, 27, 1'b1);
        request(1, 8'd32,  8'd48, 16, 1'b1);
        request(2, 8'd45,  8'd15, 15, 1'b1);
        request(3, 8'd100, 8'd50, 50, 1'b1);
        drain("simul_drain", 300);

        // Fairness: req 0 and req 2 held valid, grants alternate 0,2,0,2
        hold = 4'b0101;
        request(0, 8'd14, 8'd21, 7, 1'b1);
        request(2, 8'd9,  8'd6,  3, 1'b1);
        request(0, 8'd14, 8'd21, 7, 1'b1);
        request(2, 8'd9,  8'd6,  3, 1'b1);
        g0 = n_grant;
        n  = 0;
        while ((n_grant - g0) < 4 && n < 300) begin
            cycle();
            n++;
        end
        hold      = '0;
        req_valid = '0;
        check("fair_grants", 32'(n_grant - g0), 32'd4);
        drain("fair_drain", 300);

        // Single request with latency checks
        s0 = n_start;
        request(0, 8'd54, 8'd24, 6, 1'b1);
        drain("single_drain", 200);
        check("single_start_cnt", 32'(n_start - s0), 32'd1);
        check("single_start_lat", 32'(start_cyc - accept_cyc), 32'd1);
        check("single_resp_lat",  32'(resp_rise - done_rise), 32'd1);

        // Backpressure: response held while another request waits
        resp_ready = 1'b0;
        request(1, 8'd12, 8'd18, 6, 1'b1);
        request(3, 8'd7,  8'd21, 7, 1'b1);
        n = 0;
        while (resp_valid !== 1'b1 && n < 100) begin
            cycle();
            n++;
        end
        check("bp_resp_seen", 32'(resp_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("bp_valid",     32'(resp_valid), 32'd1);
            check("bp_id",        32'(resp_id),    32'd1);
            check("bp_gcd",       32'(resp_gcd),   32'd6);
            check("bp_req_ready", 32'(req_ready),  32'd0);
        end
        resp_ready = 1'b1;
        drain("bp_drain", 300);

        // Zero operand
        s0 = n_start;
        request(2, 8'd0, 8'd45, 45, 1'b1);
        drain("zero_drain", 200);
`ifdef GCD_ARB_ZERO_BYPASS_EN
        check("zero_start_cnt", 32'(n_start - s0), 32'd0);
        check("zero_resp_lat",  32'(resp_rise - accept_cyc), 32'd1);
`else
        check("zero_start_cnt", 32'(n_start - s0), 32'd1);
`endif

        // Reset during WAIT; engine finishes after reset is released
        s0 = n_start;
        request(0, 8'd30, 8'd12, 0, 1'b0);
        n = 0;
        while (n_start == s0 && n < 50) begin
            cycle();
            n++;
        end
        check("rst_issue_seen", 32'(n_start - s0), 32'd1);
        cycle();
        cycle();
        rst_n = 1'b0;
        cycle();
        check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_eng_start",  32'(eng_start),  32'd0);
        check("mid_rst_resp_id",    32'(resp_id),    32'd0);
        check("mid_rst_resp_gcd",   32'(resp_gcd),   32'd0);
        check("mid_rst_eng_a",      32'(eng_a),      32'd0);
        check("mid_rst_eng_b",      32'(eng_b),      32'd0);
        check("mid_rst_req_ready",  32'(req_ready),  32'd0);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (resp_valid !== 1'b0) seen = 1'b1;
        end
        check("mid_rst_no_resp", 32'(seen), 32'd0);

        // Pointer back at 0 after reset: req 0 wins over req 1
        request(0, 8'd21, 8'd14, 7, 1'b1);
        request(1, 8'd20, 8'd8,  4, 1'b1);
        drain("post_rst_drain", 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
